vdma_wr_burst_scheduler: RTL and testbench
==========================================

# vdma_wr_burst_scheduler

Write-side DDR burst scheduler for the video DMA path. Drains the 64-bit pixel FIFO filled by the video input packer and issues Avalon-MM burst writes to the DDR controller, line by line, from the base address latched at each frame start. Sits between the input packer's FIFO/frame-control outputs and the DDR write master port; one instance per input video stream.

## Interface
- ADDR_BITS, 25, DDR word address width (one address = one 64-bit beat)
- BURST_LEN, 32, maximum beats per burst (power of two, 2..64)
- LVL_BITS, 10, width of FIFO fill level
- clk  in  1  scheduler clock (same domain as the FIFO read side and DDR master)
- rst_n  in  1  asynchronous, active-low reset
- loadbase  in  1  one-cycle frame-start pulse; latches base and geometry
- ddr_baseaddr  in  ADDR_BITS  frame base word address
- ddr_line_length  in  24  beats per line
- ddr_col_length  in  12  lines per frame
- fifo_rdusedw  in  LVL_BITS  FIFO words available (show-ahead FIFO)
- fifo_rd_data  in  64  FIFO head word
- fifo_rd_en  out  1  pop FIFO head
- avm_address  out  ADDR_BITS  burst start address
- avm_burstcount  out  7  beats in current burst
- avm_write  out  1  write beat valid
- avm_writedata  out  64  write beat data
- avm_waitrequest  in  1  slave stall
- frame_done  out  1  one-cycle pulse, last beat of frame accepted
- busy  out  1  high in any state other than IDLE
- abort_cnt  out  16  frames aborted by early loadbase (see Configuration)

## Operation
- States: IDLE, LOAD, WAIT, BURST, FLUSH.
- IDLE: on loadbase latch base→line_addr/cur_addr, line_length→line_len, col_length→lines_left; go LOAD.
- LOAD: if line_len==0 or lines_left==0, pulse frame_done, go IDLE. Else beats_left=line_len, go WAIT.
- WAIT: bsize=min(BURST_LEN, beats_left). When fifo_rdusedw ≥ bsize: register avm_address=cur_addr, avm_burstcount=bsize, beat_cnt=bsize, go BURST.
- BURST: avm_write=1, avm_writedata=fifo_rd_data, fifo_rd_en=~avm_waitrequest. Each accepted beat: beat_cnt−1, beats_left−1, cur_addr+1. Address/burstcount held constant for whole burst.
- Burst end (last beat accepted): if beats_left reaches 0: lines_left−1; if lines_left reaches 0 pulse frame_done, go IDLE; else line_addr+=line_len, cur_addr=line_addr+line_len, beats_left=line_len, go WAIT. Otherwise go WAIT.
- Bursts never cross a line boundary; last burst of a line is short (line_len mod BURST_LEN).
- loadbase in WAIT: discard frame, relatch, go LOAD, abort_cnt+1.
- loadbase in BURST (upstream FIFO is being reset): go FLUSH; remaining beats of the burst issued with avm_writedata=0, fifo_rd_en=0; when last beat accepted, go LOAD with the pending (latched) base/geometry; abort_cnt+1.
- loadbase in LOAD: relatch, stay LOAD. loadbase in FLUSH: relatch pending values, continue FLUSH.
- Address arithmetic wraps modulo 2^ADDR_BITS; line_len product not computed (accumulated per line).

## Timing
- Reset: state IDLE; fifo_rd_en, avm_write, frame_done, busy = 0; avm_address, avm_burstcount, avm_writedata = 0; abort_cnt = 0.
- All outputs registered except fifo_rd_en and avm_writedata (combinational from state, waitrequest, FIFO head).
- loadbase → LOAD next cycle → WAIT next cycle; avm_write asserts the cycle after WAIT sees sufficient level.
- Minimum 1 idle cycle (WAIT) between consecutive bursts.
- frame_done asserts the cycle after final beat acceptance, same cycle busy drops.
- waitrequest high: beat held, no pop, counters frozen.

## Configuration
- VDMA_WR_ABORT_CNT_EN defined: abort_cnt counts aborted frames, saturating at 16'hFFFF, cleared only by reset.
- Undefined: counter logic removed, abort_cnt tied to 0; abort behaviour otherwise identical.

## Test plan
- Base 0x100, line 64, 2 lines, BURST_LEN 32, FIFO preloaded 128 words, waitrequest 0 -> 4 bursts at 0x100,0x120,0x140,0x160, burstcount 32, frame_done once after 128th beat.
- Line 40, 1 line -> bursts 32 @base then 8 @base+32; no burst crosses line end.
- fifo_rdusedw held at 31, then raised to 32 -> no avm_write while 31; write asserts one cycle after level reaches 32.
- Random waitrequest 50% during 32-beat burst -> exactly 32 pops, data order preserved, address/burstcount stable.
- loadbase at beat 10 of a 32-beat burst -> 22 zero-data beats with fifo_rd_en=0, then new frame from new base; abort_cnt=1 (0 without macro).
- line_length=0 -> frame_done two cycles after loadbase, no avm_write.

Source files
------------

// File: rtl/vdma_wr_burst_scheduler.sv
// Write-side DDR burst scheduler: drains the pixel FIFO into Avalon-MM bursts, line by line.
// Optional abort counter enabled by defining VDMA_WR_ABORT_CNT_EN.
module vdma_wr_burst_scheduler #(
  parameter int ADDR_BITS = 25,
  parameter int BURST_LEN = 32,
  parameter int LVL_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 loadbase,
  input  logic [ADDR_BITS-1:0] ddr_baseaddr,
  input  logic [23:0]          ddr_line_length,
  input  logic [11:0]          ddr_col_length,
  input  logic [LVL_BITS-1:0]  fifo_rdusedw,
  input  logic [63:0]          fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic [ADDR_BITS-1:0] avm_address,
  output logic [6:0]           avm_burstcount,
  output logic                 avm_write,
  output logic [63:0]          avm_writedata,
  input  logic                 avm_waitrequest,
  output logic                 frame_done,
  output logic                 busy,
  output logic [15:0]          abort_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, BURST, FLUSH} state_t;

  localparam logic [6:0] BURST_MAX = 7'(BURST_LEN);

  // Handshake: a beat transfers on every cycle with avm_write high and
  // avm_waitrequest low; address/burstcount/data hold while stalled.
  state_t               state, state_next;
  logic [ADDR_BITS-1:0] line_addr, line_addr_next;
  logic [ADDR_BITS-1:0] cur_addr, cur_addr_next;
  logic [23:0]          line_len, line_len_next;
  logic [23:0]          beats_left, beats_left_next;
  logic [11:0]          lines_left, lines_left_next;
  logic [6:0]           beat_cnt, beat_cnt_next;
  logic [6:0]           bsize;
  logic [ADDR_BITS-1:0] avm_address_next;
  logic [6:0]           avm_burstcount_next;
  logic                 avm_write_next;
  logic                 frame_done_next;
  logic                 relatch;
  logic                 beat_ok;
  logic                 last_beat;

  assign beat_ok       = avm_write && !avm_waitrequest;
  assign last_beat     = beat_ok && (beat_cnt == 7'd1);
  assign bsize         = (beats_left >= 24'(BURST_LEN)) ? BURST_MAX : beats_left[6:0];
  assign fifo_rd_en    = (state == BURST) && !avm_waitrequest;
  assign avm_writedata = (state == BURST) ? fifo_rd_data : 64'd0;

  always_comb begin
    state_next          = state;
    line_addr_next      = line_addr;
    cur_addr_next       = cur_addr;
    line_len_next       = line_len;
    beats_left_next     = beats_left;
    lines_left_next     = lines_left;
    beat_cnt_next       = beat_cnt;
    avm_address_next    = avm_address;
    avm_burstcount_next = avm_burstcount;
    avm_write_next      = avm_write;
    frame_done_next     = 1'b0;
    relatch             = 1'b0;

    case (state)
      IDLE: begin
        if (loadbase) begin
          relatch    = 1'b1;
          state_next = LOAD;
        end
      end

      LOAD: begin
        if (loadbase) begin
          relatch = 1'b1;
        end else if (line_len == 24'd0 || lines_left == 12'd0) begin
          frame_done_next = 1'b1;
          state_next      = IDLE;
        end else begin
          beats_left_next = line_len;
          state_next      = WAIT;
        end
      end

      WAIT: begin
        if (loadbase) begin
          relatch    = 1'b1;
          state_next = LOAD;
        end else if (32'(fifo_rdusedw) >= 32'(bsize)) begin
          avm_address_next    = cur_addr;
          avm_burstcount_next = bsize;
          beat_cnt_next       = bsize;
          avm_write_next      = 1'b1;
          state_next          = BURST;
        end
      end

      BURST: begin
        if (beat_ok) begin
          beat_cnt_next   = beat_cnt - 7'd1;
          beats_left_next = beats_left - 24'd1;
          cur_addr_next   = cur_addr + ADDR_BITS'(1);
        end
        if (loadbase) begin
          // Upstream FIFO is being reset: pad the rest of this burst with zeros.
          relatch = 1'b1;
          if (last_beat) begin
            avm_write_next = 1'b0;
            state_next     = LOAD;
          end else begin
            state_next = FLUSH;
          end
        end else if (last_beat) begin
          avm_write_next = 1'b0;
          state_next     = WAIT;
          if (beats_left == 24'd1) begin
            lines_left_next = lines_left - 12'd1;
            if (lines_left == 12'd1) begin
              frame_done_next = 1'b1;
              state_next      = IDLE;
            end else begin
              line_addr_next  = line_addr + ADDR_BITS'(line_len);
              cur_addr_next   = line_addr + ADDR_BITS'(line_len);
              beats_left_next = line_len;
            end
          end
        end
      end

      FLUSH: begin
        if (beat_ok) beat_cnt_next = beat_cnt - 7'd1;
        if (loadbase) relatch = 1'b1;
        if (last_beat) begin
          avm_write_next = 1'b0;
          state_next     = LOAD;
        end
      end

      default: state_next = IDLE;
    endcase

    // Frame geometry is latched straight into the working registers; LOAD
    // re-derives everything else from them.
    if (relatch) begin
      line_addr_next  = ddr_baseaddr;
      cur_addr_next   = ddr_baseaddr;
      line_len_next   = ddr_line_length;
      lines_left_next = ddr_col_length;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      line_addr      <= '0;
      cur_addr       <= '0;
      line_len       <= '0;
      beats_left     <= '0;
      lines_left     <= '0;
      beat_cnt       <= '0;
      avm_address    <= '0;
      avm_burstcount <= '0;
      avm_write      <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      line_addr      <= line_addr_next;
      cur_addr       <= cur_addr_next;
      line_len       <= line_len_next;
      beats_left     <= beats_left_next;
      lines_left     <= lines_left_next;
      beat_cnt       <= beat_cnt_next;
      avm_address    <= avm_address_next;
      avm_burstcount <= avm_burstcount_next;
      avm_write      <= avm_write_next;
      frame_done     <= frame_done_next;
      busy           <= (state_next != IDLE);
    end
  end

`ifdef VDMA_WR_ABORT_CNT_EN
  logic       abort;
  logic [15:0] abort_q;

  assign abort = loadbase && (state == WAIT || state == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      abort_q <= 16'd0;
    else if (abort && abort_q != 16'hFFFF)
      abort_q <= abort_q + 16'd1;
  end

  assign abort_cnt = abort_q;
`else
  assign abort_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vdma_wr_burst_scheduler.sv
// Bench for vdma_wr_burst_scheduler: a frame-level model expands each frame into
// expected bursts and a word-order queue, and every cycle's outputs are compared against it.
module tb_vdma_wr_burst_scheduler;
  localparam int AB = 25;
  localparam int LB = 10;
`ifdef VDMA_WR_ABORT_CNT_EN
  localparam int EXP_ABORTS = 1;
`else
  localparam int EXP_ABORTS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          loadbase;
  logic [AB-1:0] ddr_baseaddr;
  logic [23:0]   ddr_line_length;
  logic [11:0]   ddr_col_length;
  logic [LB-1:0] fifo_rdusedw;
  logic [63:0]   fifo_rd_data;
  logic          fifo_rd_en;
  logic [AB-1:0] avm_address;
  logic [6:0]    avm_burstcount;
  logic          avm_write;
  logic [63:0]   avm_writedata;
  logic          avm_waitrequest;
  logic          frame_done;
  logic          busy;
  logic [15:0]   abort_cnt;

  vdma_wr_burst_scheduler dut (
    .clk(clk), .rst_n(rst_n), .loadbase(loadbase), .ddr_baseaddr(ddr_baseaddr),
    .ddr_line_length(ddr_line_length), .ddr_col_length(ddr_col_length),
    .fifo_rdusedw(fifo_rdusedw), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .frame_done(frame_done), .busy(busy), .abort_cnt(abort_cnt)
  );

  // clock / reset-free watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [AB-1:0] addr;
    int            cnt;
    bit            last;
  } burst_t;

  burst_t        burst_q[$];
  logic [63:0]   fifo_q[$];
  logic [63:0]   exp_q[$];
  logic [AB-1:0] obs_addr[$];
  int            obs_cnt[$];

  int checks = 0, errors = 0, cycle = 0;
  int exp_fd_cycle = -10;
  bit exp_busy = 0, flush_mode = 0, gap_exp = 0, pending_pop = 0, pending_clear = 0;
  int beat_idx = 0, clear_words = 0;
  bit wait_rand = 0, feed = 0;
  int lvl_override = -1;
  bit abort_armed = 0;
  logic [AB-1:0] nb, ab_base;
  int nl, nn, ab_len, ab_lines;
  int pop_count = 0, zero_beats = 0, fd_count = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  function automatic void push_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endfunction

  // Frame -> burst list: each line split into BURST_LEN chunks, short tail last.
  function automatic void add_frame(input logic [AB-1:0] b, input int l, input int n);
    burst_t bt;
    for (int i = 0; i < n; i++) begin
      for (int off = 0; off < l; off += 32) begin
        bt.addr = AB'(64'(b) + 64'(i) * 64'(l) + 64'(off));
        bt.cnt  = (l - off < 32) ? (l - off) : 32;
        bt.last = (i == n - 1) && (off + bt.cnt == l);
        burst_q.push_back(bt);
      end
    end
  endfunction

  // scoreboard: compare every cycle against the frame model
  function automatic void check_cycle();
    logic [63:0] e;
    chk("frame_done", 64'(frame_done), 64'(cycle == exp_fd_cycle));
    if (frame_done) fd_count++;
    chk("busy", 64'(busy), 64'(exp_busy));
    if (gap_exp) begin
      chk("burst_gap", 64'(avm_write), 64'(0));
      gap_exp = 0;
    end
    if (!avm_write) begin
      chk("rd_en_idle", 64'(fifo_rd_en), 64'(0));
    end else if (burst_q.size() == 0) begin
      chk("unexpected_write", 64'(avm_write), 64'(0));
    end else begin
      chk("address", 64'(avm_address), 64'(burst_q[0].addr));
      chk("burstcount", 64'(avm_burstcount), 64'(burst_q[0].cnt));
      if (avm_waitrequest) begin
        chk("rd_en_stall", 64'(fifo_rd_en), 64'(0));
      end else begin
        if (flush_mode) begin
          chk("flush_data", avm_writedata, 64'(0));
          chk("flush_rd_en", 64'(fifo_rd_en), 64'(0));
          zero_beats++;
        end else begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL data_underrun: got %0h, expected no beat (cycle %0d)", avm_writedata, cycle);
          end else begin
            e = exp_q.pop_front();
            chk("writedata", avm_writedata, e);
          end
          chk("rd_en", 64'(fifo_rd_en), 64'(1));
        end
        beat_idx++;
        if (beat_idx == burst_q[0].cnt) begin
          obs_addr.push_back(avm_address);
          obs_cnt.push_back(int'(avm_burstcount));
          if (burst_q[0].last && !flush_mode) exp_fd_cycle = cycle + 1;
          void'(burst_q.pop_front());
          beat_idx   = 0;
          flush_mode = 0;
          gap_exp    = 1;
        end
      end
    end
    if (fifo_rd_en) begin
      pop_count++;
      pending_pop = 1;
    end
  endfunction

  // driver: one clock cycle of stimulus, then the scoreboard check
  task automatic step(input bit lb_req);
    bit lb;
    bit ab;
    logic [63:0] d;
    @(negedge clk);
    if (pending_pop) begin
      if (fifo_q.size() > 0) d = fifo_q.pop_front();
      pending_pop = 0;
    end
    if (pending_clear) begin
      fifo_q.delete();
      exp_q.delete();
      repeat (clear_words) push_word();
      pending_clear = 0;
    end
    if (feed && fifo_q.size() < 1000 && $urandom_range(0, 1) == 1) push_word();
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 64'd0;
    fifo_rdusedw = (lvl_override >= 0) ? LB'(lvl_override)
                 : LB'((fifo_q.size() > 1023) ? 1023 : fifo_q.size());
    avm_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    ab = abort_armed && avm_write && (beat_idx == 9) && !avm_waitrequest;
    lb = lb_req || ab;
    loadbase        = lb;
    ddr_baseaddr    = ab ? ab_base : nb;
    ddr_line_length = 24'(ab ? ab_len : nl);
    ddr_col_length  = 12'(ab ? ab_lines : nn);
    #1;
    check_cycle();
    if (ab) begin
      flush_mode = 1;
      while (burst_q.size() > 1) void'(burst_q.pop_back());
      add_frame(ab_base, ab_len, ab_lines);
      clear_words   = ab_len * ab_lines;
      pending_clear = 1;
      abort_armed   = 0;
    end
    if (lb) exp_busy = 1;
    if (cycle + 1 == exp_fd_cycle) exp_busy = 0;
    cycle++;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while ((burst_q.size() != 0 || cycle <= exp_fd_cycle) && n < budget) begin
      step(0);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout_%s: %0d bursts outstanding, expected 0", name, burst_q.size());
    end
  endtask

  task automatic run_frame(input logic [AB-1:0] b, input int l, input int n, input string name);
    nb = b; nl = l; nn = n;
    add_frame(b, l, n);
    if (l == 0 || n == 0) exp_fd_cycle = cycle + 2;
    step(1);
    run_until_done(name, 6000);
    step(0);
    step(0);
  endtask

  initial begin
    int fd0;
    logic [AB-1:0] rb;
    int rl, rn;

    loadbase = 0; ddr_baseaddr = '0; ddr_line_length = '0; ddr_col_length = '0;
    fifo_rdusedw = '0; fifo_rd_data = '0; avm_waitrequest = 0;
    nb = '0; nl = 0; nn = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_avm_write", 64'(avm_write), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("rst_address", 64'(avm_address), 64'(0));
    chk("rst_burstcount", 64'(avm_burstcount), 64'(0));
    chk("rst_writedata", avm_writedata, 64'(0));
    chk("rst_abort_cnt", 64'(abort_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1;

    // two 64-beat lines from a preloaded FIFO
    repeat (128) push_word();
    obs_addr.delete(); obs_cnt.delete(); fd0 = fd_count;
    run_frame(AB'(32'h100), 64, 2, "frame_a");
    chk("a_bursts", 64'(obs_addr.size()), 64'(4));
    if (obs_addr.size() == 4) begin
      chk("a_addr0", 64'(obs_addr[0]), 64'h100);
      chk("a_addr1", 64'(obs_addr[1]), 64'h120);
      chk("a_addr2", 64'(obs_addr[2]), 64'h140);
      chk("a_addr3", 64'(obs_addr[3]), 64'h160);
      chk("a_cnt3", 64'(obs_cnt[3]), 64'(32));
    end
    chk("a_frame_done_once", 64'(fd_count - fd0), 64'(1));

    // short tail burst within one line
    repeat (40) push_word();
    obs_addr.delete(); obs_cnt.delete();
    run_frame(AB'(32'h2000), 40, 1, "frame_b");
    chk("b_bursts", 64'(obs_addr.size()), 64'(2));
    if (obs_addr.size() == 2) begin
      chk("b_cnt0", 64'(obs_cnt[0]), 64'(32));
      chk("b_addr1", 64'(obs_addr[1]), 64'h2020);
      chk("b_cnt1", 64'(obs_cnt[1]), 64'(8));
    end

    // FIFO level one short of the burst, then sufficient
    repeat (32) push_word();
    lvl_override = 31;
    nb = AB'(32'h300); nl = 32; nn = 1;
    add_frame(nb, nl, nn);
    step(1);
    for (int i = 0; i < 10; i++) begin
      step(0);
      chk("write_low_lvl31", 64'(avm_write), 64'(0));
    end
    lvl_override = -1;
    step(0);
    chk("write_same_cycle_lvl32", 64'(avm_write), 64'(0));
    step(0);
    chk("write_after_lvl32", 64'(avm_write), 64'(1));
    run_until_done("frame_lvl", 6000);
    step(0);

    // random stalls during a full burst
    repeat (32) push_word();
    wait_rand = 1; pop_count = 0;
    obs_addr.delete(); obs_cnt.delete();
    run_frame(AB'(32'h5000), 32, 1, "frame_stall");
    wait_rand = 0;
    chk("stall_pops", 64'(pop_count), 64'(32));
    chk("stall_bursts", 64'(obs_addr.size()), 64'(1));

    // frame restart in the middle of a burst
    repeat (128) push_word();
    abort_armed = 1; ab_base = AB'(32'h800); ab_len = 32; ab_lines = 1;
    zero_beats = 0; obs_addr.delete(); obs_cnt.delete(); fd0 = fd_count;
    run_frame(AB'(32'h400), 64, 2, "frame_abort");
    chk("abort_zero_beats", 64'(zero_beats), 64'(22));
    chk("abort_cnt", 64'(abort_cnt), 64'(EXP_ABORTS));
    chk("abort_bursts", 64'(obs_addr.size()), 64'(2));
    if (obs_addr.size() == 2) chk("abort_new_base", 64'(obs_addr[1]), 64'h800);
    chk("abort_frame_done_once", 64'(fd_count - fd0), 64'(1));

    // degenerate geometry: no writes, immediate frame_done
    obs_addr.delete(); obs_cnt.delete(); fd0 = fd_count;
    run_frame(AB'(32'h900), 0, 3, "frame_len0");
    run_frame(AB'(32'hA00), 5, 0, "frame_lines0");
    chk("zero_no_bursts", 64'(obs_addr.size()), 64'(0));
    chk("zero_frame_dones", 64'(fd_count - fd0), 64'(2));

    // random frames with trickle-fed FIFO and random stalls, one wrapping
    feed = 1;
    for (int f = 0; f < 6; f++) begin
      rb = AB'($urandom());
      rl = $urandom_range(1, 80);
      rn = $urandom_range(1, 3);
      if (f == 2) begin
        rb = AB'(33554432 - 20);
        rl = 50;
        rn = 2;
      end
      wait_rand = 1'($urandom_range(0, 1));
      run_frame(rb, rl, rn, "frame_rand");
    end
    feed = 0; wait_rand = 0;
    chk("final_abort_cnt", 64'(abort_cnt), 64'(EXP_ABORTS));
    chk("final_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
